ram_wb_slave: RTL and testbench

Wishbone B4 slave adapter placed directly upstream of the on-chip single-port RAM (4096 × 32 bit, byte-enabled, synchronous 1-cycle read). It converts CPU/data-bus Wishbone cycles into RAM word accesses and generates `ack_o` with the correct timing for the RAM's registered read port. It supports classic single cycles and linear incrementing read bursts, which sustain one word per clock.

---
 rtl/ram_wb_slave_if.sv | 23 ++
 rtl/ram_wb_slave.sv | 95 +++++++++
 tb/tb_ram_wb_slave.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_wb_slave_if.sv
// Wishbone B4 bus bundle between a data-bus master and the RAM slave adapter.
interface ram_wb_slave_if;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [31:0] adr_i;
   logic [3:0]  sel_i;
   logic [31:0] dat_i;
   logic [2:0]  cti_i;
   logic [1:0]  bte_i;
   logic [31:0] dat_o;
   logic        ack_o;

   modport master (
      output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, cti_i, bte_i,
      input  dat_o, ack_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i, cti_i, bte_i,
      output dat_o, ack_o
   );
endinterface

// File: rtl/ram_wb_slave.sv
// Wishbone B4 slave in front of a single-port RAM with a 1-cycle registered read;
// classic cycles plus linear incrementing read bursts at one word per clock.
//
// state | meaning
// IDLE  | waiting for a request; address goes straight to the RAM
// RD    | classic read data phase, ack with the RAM output register
// WR    | classic write already committed, ack the master
// BURST | streaming reads, cnt = word currently in the RAM output register
module ram_wb_slave #(
   parameter int AW = 12
) (
   input  logic          clk_i,
   input  logic          rst_i,
   ram_wb_slave_if.slave wb,
   output logic          ram_we_o,
   output logic [AW-1:0] ram_adr_o,
   output logic [3:0]    ram_be_o,
   output logic [31:0]   ram_dat_o,
   input  logic [31:0]   ram_dat_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD    = 2'd1,
      WR    = 2'd2,
      BURST = 2'd3
   } state_t;

   state_t        state;
   logic [AW-1:0] cnt;
   logic [AW-1:0] cnt_nxt;
   logic [AW-1:0] adr_word;
   logic          req;
   logic          burst;
   logic          unused_adr;

   assign req        = wb.cyc_i & wb.stb_i;
   assign adr_word   = wb.adr_i[AW+1:2];
   assign cnt_nxt    = cnt + 1'b1;
   assign burst      = !wb.we_i && (wb.cti_i == 3'b010) && (wb.bte_i == 2'b00);
   assign unused_adr = ^{wb.adr_i[31:AW+2], wb.adr_i[1:0]};

   assign wb.dat_o  = ram_dat_i;
   assign ram_be_o  = wb.sel_i;
   assign ram_dat_o = wb.dat_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (wb.we_i) begin
                     state <= WR;
                  end else if (burst) begin
                     state <= BURST;
                     cnt   <= adr_word;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD, WR: state <= IDLE;
            BURST: begin
               if (!wb.cyc_i) begin
                  state <= IDLE;
               end else if (req) begin
                  cnt <= cnt_nxt;
                  if (wb.cti_i == 3'b111) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      wb.ack_o  = 1'b0;
      ram_we_o  = 1'b0;
      ram_adr_o = adr_word;
      case (state)
         IDLE:   ram_we_o = req & wb.we_i & !rst_i;
         RD, WR: wb.ack_o = req;
         BURST: begin
            wb.ack_o = req;
            // prefetch the next word; during a wait state re-read the held one
            ram_adr_o = wb.stb_i ? cnt_nxt : cnt;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_wb_slave.sv
// Bench for ram_wb_slave: behavioural RAM plus a shadow memory model of the
// expected contents, directed scenarios and randomized classic/burst traffic.
module tb_ram_wb_slave;
   localparam int AW = 12;
   localparam int D  = 4096;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ram_we;
   logic [AW-1:0] ram_adr;
   logic [3:0]    ram_be;
   logic [31:0]   ram_wdat;
   logic [31:0]   ram_q;

   logic [31:0] mem     [D];
   logic [31:0] ref_mem [D];

   int total = 0;
   int bad   = 0;

   ram_wb_slave_if bus ();

   ram_wb_slave #(.AW(AW)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .wb        (bus),
      .ram_we_o  (ram_we),
      .ram_adr_o (ram_adr),
      .ram_be_o  (ram_be),
      .ram_dat_o (ram_wdat),
      .ram_dat_i (ram_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
      end
      ram_q <= mem[ram_adr];
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
      bus.adr_i = '0;   bus.sel_i = '0;   bus.dat_i = '0;
      bus.cti_i = '0;   bus.bte_i = '0;
   endtask

   task automatic classic_write(input int w, input logic [3:0] sel, input logic [31:0] d,
                                input logic [2:0] cti);
      next_cycle();
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = 32'(w) << 2;
      bus.sel_i = sel; bus.dat_i = d; bus.cti_i = cti; bus.bte_i = 2'b00;
      @(negedge clk);
      total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL wr_t0_we got=%b exp=1", ram_we); end
      total++; if (ram_adr !== AW'(w)) begin bad++; $display("FAIL wr_t0_adr got=%0d exp=%0d", ram_adr, w); end
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL wr_t0_ack got=%b exp=0", bus.ack_o); end
      ref_mem[w] = merge(ref_mem[w], d, sel);
      next_cycle();
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b1) begin bad++; $display("FAIL wr_t1_ack got=%b exp=1", bus.ack_o); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL wr_t1_we got=%b exp=0", ram_we); end
      next_cycle();
      idle_bus();
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL wr_t2_ack got=%b exp=0", bus.ack_o); end
   endtask

   task automatic classic_read(input int w, output logic [31:0] got);
      next_cycle();
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 32'(w) << 2;
      bus.sel_i = 4'hF; bus.cti_i = 3'b000; bus.bte_i = 2'b00;
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL rd_t0_ack got=%b exp=0", bus.ack_o); end
      total++; if (ram_adr !== AW'(w)) begin bad++; $display("FAIL rd_t0_adr got=%0d exp=%0d", ram_adr, w); end
      next_cycle();
      @(negedge clk);
      got = bus.dat_o;
      total++; if (bus.ack_o !== 1'b1) begin bad++; $display("FAIL rd_t1_ack got=%b exp=1", bus.ack_o); end
      total++; if (bus.dat_o !== ref_mem[w]) begin bad++; $display("FAIL rd_t1_dat word=%0d got=%h exp=%h", w, bus.dat_o, ref_mem[w]); end
      next_cycle();
      idle_bus();
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL rd_t2_ack got=%b exp=0", bus.ack_o); end
   endtask

   // wait_after: beat index after which stb drops for wait_len cycles (-1 none)
   task automatic burst_read(input int base, input int n, input int wait_after,
                             input int wait_len, input bit raise_we);
      int exp_next;
      next_cycle();
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 32'(base) << 2;
      bus.sel_i = 4'hF; bus.cti_i = 3'b010; bus.bte_i = 2'b00;
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL bu_t0_ack got=%b exp=0", bus.ack_o); end
      total++; if (ram_adr !== AW'(base)) begin bad++; $display("FAIL bu_t0_adr got=%0d exp=%0d", ram_adr, base); end
      for (int k = 0; k < n; k++) begin
         next_cycle();
         bus.stb_i = 1;
         bus.adr_i = 32'((base + k) % D) << 2;
         bus.cti_i = (k == n - 1) ? 3'b111 : 3'b010;
         bus.we_i  = raise_we && (k > 0);
         exp_next  = (base + k + 1) % D;
         @(negedge clk);
         total++; if (bus.ack_o !== 1'b1) begin bad++; $display("FAIL bu_ack beat=%0d got=%b exp=1", k, bus.ack_o); end
         total++; if (bus.dat_o !== ref_mem[(base + k) % D]) begin bad++; $display("FAIL bu_dat beat=%0d got=%h exp=%h", k, bus.dat_o, ref_mem[(base + k) % D]); end
         total++; if (ram_adr !== AW'(exp_next)) begin bad++; $display("FAIL bu_adr beat=%0d got=%0d exp=%0d", k, ram_adr, exp_next); end
         total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL bu_we beat=%0d got=%b exp=0", k, ram_we); end
         if (k == wait_after) begin
            for (int j = 0; j < wait_len; j++) begin
               next_cycle();
               bus.stb_i = 0;
               @(negedge clk);
               total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL bu_wait_ack beat=%0d got=%b exp=0", k, bus.ack_o); end
               total++; if (ram_adr !== AW'(exp_next)) begin bad++; $display("FAIL bu_wait_adr got=%0d exp=%0d", ram_adr, exp_next); end
            end
         end
      end
      next_cycle();
      idle_bus();
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL bu_end_ack got=%b exp=0", bus.ack_o); end
   endtask

   task automatic test_reset();
      idle_bus();
      rst = 1'b1;
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", bus.ack_o); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", ram_we); end
      next_cycle();
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = 32'h20;
      bus.sel_i = 4'hF; bus.dat_i = 32'h1234_5678;
      @(negedge clk);
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_req_we got=%b exp=0", ram_we); end
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL rst_req_ack got=%b exp=0", bus.ack_o); end
      next_cycle();
      idle_bus();
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         total++; if (bus.ack_o !== 1'b0 || ram_we !== 1'b0) begin bad++; $display("FAIL post_rst ack=%b we=%b exp=0,0", bus.ack_o, ram_we); end
      end
   endtask

   task automatic test_classic();
      logic [31:0] got;
      classic_write(4, 4'b1111, 32'hDEAD_BEEF, 3'b000);
      classic_read(4, got);
      total++; if (got !== 32'hDEAD_BEEF) begin bad++; $display("FAIL readback got=%h exp=deadbeef", got); end
      classic_write(4, 4'b0100, 32'h00AA_0000, 3'b000);
      classic_read(4, got);
      total++; if (got !== 32'hDEAA_BEEF) begin bad++; $display("FAIL byte_write got=%h exp=deaabeef", got); end
      classic_read(8, got); // word 8 was the target of the write attempted under reset
   endtask

   task automatic test_back_to_back();
      next_cycle();
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 32'd100 << 2;
      bus.sel_i = 4'hF; bus.cti_i = 3'b010; bus.bte_i = 2'b01;
      next_cycle();
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b1 || bus.dat_o !== ref_mem[100]) begin bad++; $display("FAIL b2b_t1 ack=%b dat=%h exp=1,%h", bus.ack_o, bus.dat_o, ref_mem[100]); end
      next_cycle();
      bus.adr_i = 32'd101 << 2;
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL b2b_t2_ack got=%b exp=0", bus.ack_o); end
      total++; if (ram_adr !== AW'(101)) begin bad++; $display("FAIL b2b_t2_adr got=%0d exp=101", ram_adr); end
      next_cycle();
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b1 || bus.dat_o !== ref_mem[101]) begin bad++; $display("FAIL b2b_t3 ack=%b dat=%h exp=1,%h", bus.ack_o, bus.dat_o, ref_mem[101]); end
      next_cycle();
      idle_bus();
      classic_write(200, 4'b0011, 32'hCAFE_F00D, 3'b010);
      classic_read(200, ref_mem[0]);
      ref_mem[0] = mem[0];
   endtask

   task automatic test_burst_abort_cyc();
      logic [31:0] got;
      burst_read(50, 0, -1, 0, 1'b0);
      next_cycle();
      bus.cyc_i = 1; bus.stb_i = 1; bus.adr_i = 32'd60 << 2; bus.cti_i = 3'b010;
      bus.sel_i = 4'hF;
      next_cycle();
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b1 || bus.dat_o !== ref_mem[60]) begin bad++; $display("FAIL abc_beat ack=%b dat=%h exp=1,%h", bus.ack_o, bus.dat_o, ref_mem[60]); end
      next_cycle();
      idle_bus();
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL abc_drop_ack got=%b exp=0", bus.ack_o); end
      classic_read(7, got);
   endtask

   task automatic test_burst_abort_rst();
      logic [31:0] got;
      next_cycle();
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 32'd300 << 2;
      bus.sel_i = 4'hF; bus.cti_i = 3'b010; bus.bte_i = 2'b00;
      next_cycle();
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b1 || bus.dat_o !== ref_mem[300]) begin bad++; $display("FAIL abr_beat ack=%b dat=%h exp=1,%h", bus.ack_o, bus.dat_o, ref_mem[300]); end
      next_cycle();
      rst = 1'b1;
      bus.we_i = 1; bus.adr_i = 32'd9 << 2; bus.dat_i = 32'h5555_AAAA;
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL abr_rst_ack got=%b exp=0", bus.ack_o); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL abr_rst_we got=%b exp=0", ram_we); end
      next_cycle();
      rst = 1'b0;
      idle_bus();
      @(negedge clk);
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL abr_after_ack got=%b exp=0", bus.ack_o); end
      classic_read(7, got);
      classic_read(9, got);
   endtask

   task automatic test_random();
      logic [31:0] got;
      int w, n;
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 2))
            0: begin
               w = $urandom_range(0, 63);
               classic_write(w, 4'($urandom_range(1, 15)), $urandom, 3'b000);
            end
            1: classic_read($urandom_range(0, 63), got);
            default: begin
               n = $urandom_range(1, 6);
               w = ($urandom_range(0, 1) == 1) ? $urandom_range(D - 4, D - 1) : $urandom_range(0, 63);
               burst_read(w, n, (n > 1) ? $urandom_range(0, n - 2) : -1,
                          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
         endcase
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < D; i++) begin
         ref_mem[i] = $urandom;
         mem[i]     = ref_mem[i];
      end
      idle_bus();
      test_reset();
      test_classic();
      test_back_to_back();
      burst_read(4094, 4, -1, 0, 1'b0);
      burst_read(20, 5, 1, 2, 1'b0);
      burst_read(4093, 6, 2, 1, 1'b1);
      test_burst_abort_cyc();
      test_burst_abort_rst();
      test_random();
      next_cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
